sram22_arb2: RTL and testbench
==============================

# sram22_arb2

Two-requester arbiter and response sequencer for one single-port sram22 macro (default 512x64, 8-bit write mask). Each requester issues reads and masked writes through a valid/ready request channel. Read data returns on a per-port valid/ready response channel buffered by a small FIFO, so the macro's one-cycle, non-held read data is never lost. The block sits between two bus clients (e.g. core and DMA) and the macro pins.

## Interface
- DATA_WIDTH, 64, word width; must equal macro word.
- ADDR_WIDTH, 9, word address width.
- WMASK_WIDTH, 8, byte-lane write mask width; DATA_WIDTH/WMASK_WIDTH bits per lane.
- RSP_DEPTH, 3, per-port response FIFO entries; legal values are 2 or more, and 3 gives full read throughput.
- clk  in  1  single clock, shared with macro.
- rst  in  1  asynchronous, active-high reset.
- req{0,1}_valid  in  1  request present.
- req{0,1}_ready  out  1  request accepted this cycle.
- req{0,1}_we  in  1  1=write, 0=read.
- req{0,1}_wmask  in  WMASK_WIDTH  byte enables (writes only).
- req{0,1}_addr  in  ADDR_WIDTH  word address.
- req{0,1}_wdata  in  DATA_WIDTH  write data.
- rsp{0,1}_valid  out  1  read data available.
- rsp{0,1}_ready  in  1  requester consumes read data.
- rsp{0,1}_rdata  out  DATA_WIDTH  read data.
- sram_we  out  1  to macro we.
- sram_wmask  out  WMASK_WIDTH  to macro wmask.
- sram_addr  out  ADDR_WIDTH  to macro addr.
- sram_din  out  DATA_WIDTH  to macro din.
- sram_dout  in  DATA_WIDTH  from macro dout.

## Operation
- Request handshake: a transfer occurs when valid&&ready. The requester holds valid and all fields stable until ready.
- req_ready is combinational from req_valid, eligibility and the round-robin pointer. No combinational path from rsp_ready to req_ready.
- Eligibility: writes are always eligible. A read on port i is eligible only when credit_i < RSP_DEPTH.
- credit_i counts entries in FIFO_i plus reads in flight for port i.
- credit_i increments on a read accept, decrements on an rsp_i handshake, and is unchanged when both happen in the same cycle.
- Arbitration: at most one grant per cycle.
- If only one port is valid and eligible, that port is granted. If both are, the port named by rr_ptr is granted.
- After any grant, rr_ptr points to the non-granted port. rr_ptr is unchanged on idle cycles.
- Macro drive (combinational from the granted request): sram_we=we, sram_wmask=wmask, sram_addr=addr, sram_din=wdata.
- No grant: all sram_* outputs driven 0. The macro then performs a harmless read of address 0, which is ignored.
- Read tracking: on a read grant, register pend_v=1 and pend_port=i.
- In the next cycle, sram_dout is pushed into FIFO_pend_port and pend_v clears unless a new read is granted.
- Writes produce no response.
- Ordering: accesses are performed in grant order. A read granted the cycle after a write to the same address returns the new data, on either port.
- Responses per port come out in request order.
- rsp_i_valid = FIFO_i non-empty; rsp_i_rdata = FIFO_i head.
- FIFO overflow is impossible by the credit rule; the bench asserts this.
- Reset (any time, including mid-transfer): FIFOs emptied, credits 0, pend_v 0, rr_ptr=0. In-flight read data is discarded.

## Timing
- Reset values: req_ready 0 (forced low while rst is high), rsp_valid 0, rsp_rdata 0, sram_we 0, sram_wmask 0, sram_addr 0, sram_din 0.
- Request accepted in cycle N, which is also when the macro samples it at the end of N.
- Read data is on sram_dout in N+1, captured at the end of N+1, and rsp_valid=1 in N+2.
- Write visible to any read granted in N+1 or later.
- Throughput: one access per cycle total.
- A single port with rsp_ready held high sustains one read per cycle when RSP_DEPTH>=3.
- With RSP_DEPTH=2, a single port's read throughput falls below one per cycle.
- Simultaneous rsp pop and FIFO push in the same cycle on the same port are both honoured.

## Test plan
- Write and read back on the same port: port0 writes addr 5, wdata 0x0123456789ABCDEF, wmask 0xFF. Port0 then reads addr 5. Required: rsp0_valid two cycles after the read accept, with rdata 0x0123456789ABCDEF.
- Partial mask: write 0xFFFF...FF to addr 7, then a write with wmask 0x0F and data 0. Required: read of addr 7 returns 0xFFFFFFFF00000000.
- Contention: both ports issue back-to-back reads for 10 cycles. Required: grants alternate 0,1,0,1 with no idle cycles, and each port receives 5 responses in order.
- Backpressure: rsp1_ready=0 while port1 issues 5 reads. Required: exactly RSP_DEPTH reads accepted, then req1_ready stays 0 while port0 keeps being granted.
- Backpressure release: after the previous scenario, raise rsp1_ready. Required: the remaining reads complete with correct data.
- Streaming plus reset: port0 streams reads to addrs 0..15 with rsp0_ready=1. Required: one grant per cycle and rdata matching previously written values. Asserting rst mid-stream clears all rsp_valid immediately, and no stale response appears after reset deasserts.

Source files
------------

// File: rtl/sram22_arb2.sv
// sram22_arb2: two-requester arbiter and response sequencer for one
// single-port sram22 macro. Round-robin grant of one access per cycle,
// credit-limited reads, per-port response FIFOs that catch the macro's
// one-cycle read data.
module sram22_arb2 #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 9,
   parameter int WMASK_WIDTH = 8,
   parameter int RSP_DEPTH   = 3
) (
   input  logic                   clk,
   input  logic                   rst,

   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic                   req0_we,
   input  logic [WMASK_WIDTH-1:0] req0_wmask,
   input  logic [ADDR_WIDTH-1:0]  req0_addr,
   input  logic [DATA_WIDTH-1:0]  req0_wdata,

   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic                   req1_we,
   input  logic [WMASK_WIDTH-1:0] req1_wmask,
   input  logic [ADDR_WIDTH-1:0]  req1_addr,
   input  logic [DATA_WIDTH-1:0]  req1_wdata,

   output logic                   rsp0_valid,
   input  logic                   rsp0_ready,
   output logic [DATA_WIDTH-1:0]  rsp0_rdata,

   output logic                   rsp1_valid,
   input  logic                   rsp1_ready,
   output logic [DATA_WIDTH-1:0]  rsp1_rdata,

   output logic                   sram_we,
   output logic [WMASK_WIDTH-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_din,
   input  logic [DATA_WIDTH-1:0]  sram_dout
);

   // Credit counter must hold 0..RSP_DEPTH; FIFO pointers index 0..RSP_DEPTH-1.
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

   // Per-port views of the two request/response channels.
   logic [1:0]                  valid;
   logic [1:0]                  we;
   logic [1:0][WMASK_WIDTH-1:0] wmask;
   logic [1:0][ADDR_WIDTH-1:0]  addr;
   logic [1:0][DATA_WIDTH-1:0]  wdata;
   logic [1:0][DATA_WIDTH-1:0]  rdata;
   logic [1:0]                  rsp_rdy;
   logic [1:0]                  rsp_vld;

   // Arbitration and read-tracking state.
   logic [1:0] elig;
   logic [1:0] grant;
   logic [1:0] rd_acc;
   logic [1:0] push;
   logic [1:0] pop;
   logic       rr_ptr;
   logic       pend_v;
   logic       pend_port;

   assign valid   = {req1_valid, req0_valid};
   assign we      = {req1_we, req0_we};
   assign wmask   = {req1_wmask, req0_wmask};
   assign addr    = {req1_addr, req0_addr};
   assign wdata   = {req1_wdata, req0_wdata};
   assign rsp_rdy = {rsp1_ready, rsp0_ready};

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign rsp0_valid = rsp_vld[0];
   assign rsp1_valid = rsp_vld[1];
   assign rsp0_rdata = rdata[0];
   assign rsp1_rdata = rdata[1];

   // Per-port credit tracking and response FIFO.
   for (genvar i = 0; i < 2; i++) begin : g_port
      logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
      logic [PW-1:0]         wr_ptr;
      logic [PW-1:0]         rd_ptr;
      logic [CW-1:0]         count;
      logic [CW-1:0]         credit;

      // A read is only eligible while its response is guaranteed a FIFO slot.
      assign elig[i]    = valid[i] && (we[i] || (credit < DEPTH_C));
      assign rd_acc[i]  = grant[i] && !we[i];
      assign push[i]    = pend_v && (pend_port == 1'(i));
      assign pop[i]     = rsp_vld[i] && rsp_rdy[i];
      assign rsp_vld[i] = (count != '0);
      assign rdata[i]   = rsp_vld[i] ? mem[rd_ptr] : '0;

      // FIFO storage: captures macro read data the cycle after the grant.
      always_ff @(posedge clk) begin
         if (push[i]) begin
            mem[wr_ptr] <= sram_dout;
         end
      end

      // FIFO pointers, occupancy and outstanding-read credit.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            credit <= '0;
         end else begin
            if (push[i]) begin
               wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop[i]) begin
               rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count  <= count + CW'(push[i]) - CW'(pop[i]);
            credit <= credit + CW'(rd_acc[i]) - CW'(pop[i]);
         end
      end
   end

   // Round-robin grant among eligible ports; nothing granted during reset.
   always_comb begin
      grant = '0;
      if (!rst) begin
         if (elig[0] && (!elig[1] || (rr_ptr == 1'b0))) begin
            grant[0] = 1'b1;
         end else if (elig[1]) begin
            grant[1] = 1'b1;
         end
      end
   end

   // Macro pins follow the granted request; idle cycles drive all zeros.
   always_comb begin
      sram_we    = 1'b0;
      sram_wmask = '0;
      sram_addr  = '0;
      sram_din   = '0;
      if (grant[0]) begin
         sram_we    = we[0];
         sram_wmask = wmask[0];
         sram_addr  = addr[0];
         sram_din   = wdata[0];
      end else if (grant[1]) begin
         sram_we    = we[1];
         sram_wmask = wmask[1];
         sram_addr  = addr[1];
         sram_din   = wdata[1];
      end
   end

   // Round-robin pointer and one-deep in-flight read tracker.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= 1'b0;
         pend_v    <= 1'b0;
         pend_port <= 1'b0;
      end else begin
         if (grant[0]) begin
            rr_ptr <= 1'b1;
         end else if (grant[1]) begin
            rr_ptr <= 1'b0;
         end
         pend_v    <= |rd_acc;
         pend_port <= rd_acc[1];
      end
   end

endmodule

// File: tb/tb_sram22_arb2.sv
// Self-checking bench for sram22_arb2: behavioural macro, shadow-memory
// reference with per-port expected-response queues, directed scenarios and
// randomized two-port traffic.
module tb_sram22_arb2;

   localparam int DW = 64;
   localparam int AW = 9;
   localparam int MW = 8;
   localparam int D  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid, req0_ready, req0_we;
   logic [MW-1:0] req0_wmask;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          req1_valid, req1_ready, req1_we;
   logic [MW-1:0] req1_wmask;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [DW-1:0] rsp0_rdata, rsp1_rdata;
   logic          sram_we;
   logic [MW-1:0] sram_wmask;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din;
   logic [DW-1:0] sram_dout = '0;

   always #5 clk = ~clk;

   sram22_arb2 #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .RSP_DEPTH(D)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_wmask(req1_wmask), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
      .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // Behavioural single-port macro: masked write, registered one-cycle read.
   logic [DW-1:0] mac [512];
   always @(posedge clk) begin
      if (sram_we) begin
         for (int b = 0; b < MW; b++) begin
            if (sram_wmask[b]) mac[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
         end
      end else begin
         sram_dout <= mac[sram_addr];
      end
   end

   // Reference: memory contents as seen in grant order, expected responses per port.
   logic [DW-1:0] ref_mem [512];
   logic [DW-1:0] exp_q [2][$];
   logic [DW-1:0] last_rd [2];
   int            acc_cnt [2];
   int            glog [$];
   bit            log_en = 1'b0;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: responses first (pop), then this cycle's grant (push / memory update).
   always @(negedge clk) begin
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            logic          v, r;
            logic [DW-1:0] d;
            v = (p == 0) ? rsp0_valid : rsp1_valid;
            r = (p == 0) ? rsp0_ready : rsp1_ready;
            d = (p == 0) ? rsp0_rdata : rsp1_rdata;
            if (v) begin
               chk("rsp_expected", 64'(exp_q[p].size() > 0), 64'd1);
               if (r && exp_q[p].size() > 0) begin
                  logic [DW-1:0] e;
                  e = exp_q[p].pop_front();
                  chk(p == 0 ? "rdata0" : "rdata1", d, e);
                  last_rd[p] = d;
               end
            end
         end
         chk("one_grant", 64'(req0_ready && req1_ready), 64'd0);
         begin
            int            gp;
            logic          w;
            logic [MW-1:0] m;
            logic [AW-1:0] a;
            logic [DW-1:0] wd;
            gp = req0_ready ? 0 : (req1_ready ? 1 : -1);
            w  = (gp == 0) ? req0_we    : req1_we;
            m  = (gp == 0) ? req0_wmask : req1_wmask;
            a  = (gp == 0) ? req0_addr  : req1_addr;
            wd = (gp == 0) ? req0_wdata : req1_wdata;
            if (gp >= 0) begin
               chk("sram_ctl", 64'({sram_we, sram_wmask, sram_addr}), 64'({w, m, a}));
               chk("sram_din", sram_din, wd);
               acc_cnt[gp]++;
               if (w) begin
                  for (int b = 0; b < MW; b++) begin
                     if (m[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
                  end
               end else begin
                  exp_q[gp].push_back(ref_mem[a]);
               end
            end else begin
               chk("sram_idle", 64'({sram_we, sram_wmask, sram_addr}) | 64'(sram_din), 64'd0);
            end
            if (log_en) glog.push_back(gp);
         end
         chk("credit_bound0", 64'(exp_q[0].size() <= D), 64'd1);
         chk("credit_bound1", 64'(exp_q[1].size() <= D), 64'd1);
      end
   end

   task automatic set_req(input int p, input logic v, input logic w, input logic [MW-1:0] m,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin
         req0_valid = v; req0_we = w; req0_wmask = m; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_we = w; req1_wmask = m; req1_addr = a; req1_wdata = d;
      end
   endtask

   // Present one request and hold it until accepted (bounded wait).
   task automatic do_req(input int p, input logic w, input logic [MW-1:0] m,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
      set_req(p, 1'b1, w, m, a, d);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!rst && ((p == 0) ? req0_ready : req1_ready)) begin
            @(posedge clk); #1;
            set_req(p, 1'b0, 1'b0, '0, '0, '0);
            return;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: port %0d got no ready within 300 cycles", p);
      set_req(p, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic drain();
      for (int k = 0; k < 200; k++) begin
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
         @(posedge clk); #1;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("drain0", 64'(exp_q[0].size()), 64'd0);
      chk("drain1", 64'(exp_q[1].size()), 64'd0);
   endtask

   task automatic span_of(input int port, output int cnt, output int span);
      int first, last;
      first = -1; last = -1; cnt = 0;
      for (int k = 0; k < glog.size(); k++) begin
         if (glog[k] == port || (port == 2 && glog[k] >= 0)) begin
            if (first < 0) first = k;
            last = k;
            cnt++;
         end
      end
      span = (first < 0) ? 0 : last - first + 1;
   endtask

   initial begin
      int a0, a1, cnt, span, alt, prev, rnd_done;
      for (int i = 0; i < 512; i++) begin
         mac[i] = '0;
         ref_mem[i] = '0;
      end
      acc_cnt[0] = 0; acc_cnt[1] = 0;
      last_rd[0] = '0; last_rd[1] = '0;
      set_req(0, 1'b1, 1'b1, 8'hFF, 9'd3, 64'hDEAD);
      set_req(1, 1'b0, 1'b0, '0, '0, '0);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;

      // Reset values, with a request pending to show ready is forced low.
      #1;
      chk("rst_req0_ready", 64'(req0_ready), 64'd0);
      chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
      chk("rst_rdata", rsp0_rdata | rsp1_rdata, 64'd0);
      chk("rst_sram", 64'({sram_we, sram_wmask, sram_addr}) | 64'(sram_din), 64'd0);
      set_req(0, 1'b0, 1'b0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Preload addresses 0..31 through port1.
      for (int i = 0; i < 32; i++) do_req(1, 1'b1, 8'hFF, AW'(i), {$urandom, $urandom});

      // Write then read back on port0; response two cycles after the read accept.
      do_req(0, 1'b1, 8'hFF, 9'd5, 64'h0123456789ABCDEF);
      do_req(0, 1'b0, 8'h00, 9'd5, '0);
      @(negedge clk);
      chk("lat_n1_valid", 64'(rsp0_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_n2_valid", 64'(rsp0_valid), 64'd1);
      chk("rd5", rsp0_rdata, 64'h0123456789ABCDEF);

      // Partial-mask write.
      do_req(0, 1'b1, 8'hFF, 9'd7, '1);
      do_req(0, 1'b1, 8'h0F, 9'd7, '0);
      do_req(0, 1'b0, 8'h00, 9'd7, '0);
      repeat (3) @(posedge clk);
      #1 chk("mask7", last_rd[0], 64'hFFFFFFFF00000000);

      // Contention: both ports stream 5 reads each.
      glog.delete();
      log_en = 1'b1;
      fork
         for (int i = 0; i < 5; i++) do_req(0, 1'b0, '0, AW'(i), '0);
         for (int i = 0; i < 5; i++) do_req(1, 1'b0, '0, AW'(10 + i), '0);
      join
      log_en = 1'b0;
      span_of(2, cnt, span);
      chk("cont_grants", 64'(cnt), 64'd10);
      chk("cont_span", 64'(span), 64'd10);
      alt = 0; prev = -1;
      foreach (glog[k]) begin
         if (glog[k] >= 0) begin
            if (prev >= 0 && glog[k] != prev) alt++;
            prev = glog[k];
         end
      end
      chk("cont_alternate", 64'(alt), 64'd9);
      drain();

      // Backpressure on port1 while port0 keeps reading; then release.
      rsp1_ready = 1'b0;
      a0 = acc_cnt[0];
      a1 = acc_cnt[1];
      fork
         for (int i = 0; i < 5; i++) do_req(1, 1'b0, '0, AW'(20 + i), '0);
         for (int i = 0; i < 8; i++) do_req(0, 1'b0, '0, AW'(i), '0);
         begin
            repeat (25) @(posedge clk);
            #1;
            chk("bp_port1_accepts", 64'(acc_cnt[1] - a1), 64'(D));
            chk("bp_port0_accepts", 64'(acc_cnt[0] - a0), 64'd8);
            rsp1_ready = 1'b1;
         end
      join
      chk("bp_release_accepts", 64'(acc_cnt[1] - a1), 64'd5);
      drain();

      // Streaming reads 0..15 on port0: one grant per cycle.
      glog.delete();
      log_en = 1'b1;
      for (int i = 0; i < 16; i++) do_req(0, 1'b0, '0, AW'(i), '0);
      log_en = 1'b0;
      span_of(0, cnt, span);
      chk("stream_grants", 64'(cnt), 64'd16);
      chk("stream_span", 64'(span), 64'd16);
      drain();

      // Streaming with an asynchronous reset mid-stream.
      fork
         for (int i = 0; i < 16; i++) do_req(0, 1'b0, '0, AW'(i), '0);
         begin
            repeat (6) @(posedge clk);
            #3 rst = 1'b1;
            #1;
            chk("mid_rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
            chk("mid_rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
            chk("mid_rst_sram", 64'({sram_we, sram_wmask, sram_addr}), 64'd0);
            exp_q[0].delete();
            exp_q[1].delete();
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      drain();

      // Randomized traffic on both ports with random response backpressure.
      rnd_done = 0;
      fork
         begin
            for (int i = 0; i < 60; i++)
               do_req(0, 1'($urandom_range(0, 1)), MW'($urandom), AW'($urandom_range(0, 15)),
                      {$urandom, $urandom});
            rnd_done++;
         end
         begin
            for (int i = 0; i < 60; i++)
               do_req(1, 1'($urandom_range(0, 1)), MW'($urandom), AW'($urandom_range(0, 15)),
                      {$urandom, $urandom});
            rnd_done++;
         end
         begin
            for (int k = 0; k < 3000 && rnd_done < 2; k++) begin
               @(posedge clk); #1;
               rsp0_ready = 1'($urandom_range(0, 1));
               rsp1_ready = 1'($urandom_range(0, 1));
            end
            rsp0_ready = 1'b1;
            rsp1_ready = 1'b1;
         end
      join
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
